// File: rtl/lane_sched_pkg.sv
// Shared types and arbitration helpers for the lane scheduler.
// LANE_SCHED_GAP_EN adds a blank GAP cycle between grants.
package lane_sched_pkg;

    localparam int MAX_REQ = 16;
    localparam int PTR_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // Search upward from last+1, wrapping at nreq (not at a power of two).
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   last,
        input int unsigned        nreq
    );
        pick_t            r;
        logic [PTR_W-1:0] idx;
        r   = '0;
        idx = last;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < nreq && !r.valid) begin
                idx = (32'(idx) == nreq - 1) ? '0 : idx + 1'b1;
                if (req[idx]) begin
                    r.valid = 1'b1;
                    r.idx   = idx;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(
        input logic [PTR_W-1:0] idx
    );
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/lane_rr_arbiter.sv
// Combinational round-robin pick: (req, last owner) -> (winner, valid).
// Shared by all build variants, including LANE_SCHED_GAP_EN.
module lane_rr_arbiter
    import lane_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] last_i,
    output logic [PTR_W-1:0] winner_o,
    output logic             valid_o
);

    pick_t pick;

    always_comb begin
        pick = rr_pick(MAX_REQ'(req_i), last_i, NREQ);
    end

    assign winner_o = pick.idx;
    assign valid_o  = pick.valid;

endmodule

// File: rtl/lane_scheduler.sv
// Round-robin owner of the VAL lane bus with a programmable dwell per grant.
// Define LANE_SCHED_GAP_EN to insert one blank GAP cycle after every grant.
module lane_scheduler
    import lane_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int CW    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_val,
    input  logic [CW-1:0]         dwell,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      VAL,
    output logic                  done,
    output logic                  busy
);

    state_t           state_q;
    logic [NREQ-1:0]  grant_q;
    logic [WIDTH-1:0] val_q;
    logic             done_q;
    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [PTR_W-1:0] last_q;

    logic [PTR_W-1:0] win;
    logic             win_vld;
    logic [CW-1:0]    cnt_d;
    logic [NREQ-1:0]  grant_d;
    logic [WIDTH-1:0] val_d;

    lane_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req_i   (req),
        .last_i  (last_q),
        .winner_o(win),
        .valid_o (win_vld)
    );

    // A dwell of 0 behaves as 1: counter holds cycles-remaining minus one.
    assign cnt_d   = (dwell == '0) ? '0 : dwell - CW'(1);
    assign grant_d = NREQ'(onehot(win));
    assign val_d   = req_val[int'(win)*WIDTH +: WIDTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            val_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= PTR_W'(NREQ - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q <= HOLD;
                        grant_q <= grant_d;
                        val_q   <= val_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= cnt_d;
                        done_q  <= (cnt_d == '0);
                        last_q  <= win;
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q  <= cnt_q - CW'(1);
                        done_q <= (cnt_q == CW'(1));
                    end else begin
`ifdef LANE_SCHED_GAP_EN
                        state_q <= GAP;
                        grant_q <= '0;
                        val_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
`else
                        if (win_vld) begin
                            grant_q <= grant_d;
                            val_q   <= val_d;
                            cnt_q   <= cnt_d;
                            done_q  <= (cnt_d == '0);
                            last_q  <= win;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            val_q   <= '0;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end
`endif
                    end
                end
                GAP: begin
                    if (win_vld) begin
                        state_q <= HOLD;
                        grant_q <= grant_d;
                        val_q   <= val_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= cnt_d;
                        done_q  <= (cnt_d == '0);
                        last_q  <= win;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant = grant_q;
    assign VAL   = val_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Self-checking bench for lane_scheduler: vector tables, directed corners,
// and randomized traffic against a grant-level reference model.
module tb_lane_scheduler;

`ifdef LANE_SCHED_GAP_EN
    localparam bit GAPEN = 1'b1;
`else
    localparam bit GAPEN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_val = '0;
    logic [7:0]  dwell = '0;
    logic [3:0]  grant;
    logic [3:0]  VAL;
    logic        done;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    lane_scheduler #(
        .NREQ(4),
        .WIDTH(4),
        .CW(8)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .req    (req),
        .req_val(req_val),
        .dwell  (dwell),
        .grant  (grant),
        .VAL    (VAL),
        .done   (done),
        .busy   (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          rst;
        logic [3:0]  rq;
        logic [15:0] rv;
        logic [7:0]  dw;
        logic [3:0]  g;
        logic [3:0]  v;
        bit          d;
        bit          b;
    } vec_t;

    vec_t tbl[$];

    // Reference model: current owner and cycles left in its grant.
    int         m_own  = -1;
    int         m_rem  = 0;
    int         m_last = 3;
    bit         m_gap  = 1'b0;
    logic [3:0] m_pat  = '0;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic arbitrate();
        m_own = -1;
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (m_own < 0 && req[i]) begin
                m_own  = i;
                m_pat  = req_val[i*4 +: 4];
                m_rem  = (dwell == 0) ? 1 : int'(dwell);
                m_last = i;
            end
        end
    endtask

    task automatic model_step();
        if (RST) begin
            m_own  = -1;
            m_rem  = 0;
            m_last = 3;
            m_gap  = 1'b0;
        end else if (m_own >= 0 && m_rem > 1) begin
            m_rem--;
        end else if (m_own >= 0) begin
            if (GAPEN) begin
                m_own = -1;
                m_gap = 1'b1;
            end else begin
                arbitrate();
            end
        end else begin
            m_gap = 1'b0;
            arbitrate();
        end
    endtask

    task automatic tick();
        logic [3:0] eg;
        @(posedge CLK);
        #1;
        model_step();
        eg = (m_own >= 0) ? 4'(1 << m_own) : 4'h0;
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_val", 32'(VAL), (m_own >= 0) ? 32'(m_pat) : 32'h0);
        chk("model_done", 32'(done), 32'(m_own >= 0 && m_rem == 1));
        chk("model_busy", 32'(busy), 32'(m_own >= 0 || m_gap));
    endtask

    task automatic expect_out(string nm, logic [3:0] g, logic [3:0] v, bit d, bit b);
        chk({nm, "_grant"}, 32'(grant), 32'(g));
        chk({nm, "_val"}, 32'(VAL), 32'(v));
        chk({nm, "_done"}, 32'(done), 32'(d));
        chk({nm, "_busy"}, 32'(busy), 32'(b));
    endtask

    function automatic vec_t mk(bit r, logic [3:0] q, logic [15:0] rv, logic [7:0] dw,
                                logic [3:0] g, logic [3:0] v, bit d, bit b);
        vec_t x;
        x.rst = r; x.rq = q; x.rv = rv; x.dw = dw;
        x.g = g; x.v = v; x.d = d; x.b = b;
        return x;
    endfunction

    initial begin
        if (GAPEN) begin
            tbl.push_back(mk(1, 4'h0, 16'h00C3, 8'd2, 4'h0, 4'h0, 0, 0));
            tbl.push_back(mk(0, 4'h3, 16'h00C3, 8'd2, 4'h1, 4'h3, 0, 1));
            tbl.push_back(mk(0, 4'h3, 16'h00C3, 8'd2, 4'h1, 4'h3, 1, 1));
            tbl.push_back(mk(0, 4'h3, 16'h00C3, 8'd2, 4'h0, 4'h0, 0, 1));
            tbl.push_back(mk(0, 4'h3, 16'h00C3, 8'd2, 4'h2, 4'hC, 0, 1));
            tbl.push_back(mk(0, 4'h0, 16'h00C3, 8'd2, 4'h2, 4'hC, 1, 1));
            tbl.push_back(mk(0, 4'h0, 16'h00C3, 8'd2, 4'h0, 4'h0, 0, 1));
            tbl.push_back(mk(0, 4'h0, 16'h00C3, 8'd2, 4'h0, 4'h0, 0, 0));
        end else begin
            tbl.push_back(mk(1, 4'h0, 16'h000A, 8'd3, 4'h0, 4'h0, 0, 0));
            tbl.push_back(mk(0, 4'h1, 16'h000A, 8'd3, 4'h1, 4'hA, 0, 1));
            tbl.push_back(mk(0, 4'h0, 16'h000A, 8'd3, 4'h1, 4'hA, 0, 1));
            tbl.push_back(mk(0, 4'h0, 16'h000A, 8'd3, 4'h1, 4'hA, 1, 1));
            tbl.push_back(mk(0, 4'h0, 16'h000A, 8'd3, 4'h0, 4'h0, 0, 0));
            tbl.push_back(mk(1, 4'hF, 16'h8421, 8'd1, 4'h0, 4'h0, 0, 0));
            tbl.push_back(mk(0, 4'hF, 16'h8421, 8'd1, 4'h1, 4'h1, 1, 1));
            tbl.push_back(mk(0, 4'hF, 16'h8421, 8'd1, 4'h2, 4'h2, 1, 1));
            tbl.push_back(mk(0, 4'hF, 16'h8421, 8'd1, 4'h4, 4'h4, 1, 1));
            tbl.push_back(mk(0, 4'hF, 16'h8421, 8'd1, 4'h8, 4'h8, 1, 1));
            tbl.push_back(mk(0, 4'hF, 16'h8421, 8'd1, 4'h1, 4'h1, 1, 1));
            tbl.push_back(mk(0, 4'h0, 16'h8421, 8'd1, 4'h0, 4'h0, 0, 0));
            tbl.push_back(mk(0, 4'h4, 16'h0500, 8'd0, 4'h4, 4'h5, 1, 1));
            tbl.push_back(mk(0, 4'h0, 16'h0500, 8'd0, 4'h0, 4'h0, 0, 0));
        end

        foreach (tbl[i]) begin
            RST     = tbl[i].rst;
            req     = tbl[i].rq;
            req_val = tbl[i].rv;
            dwell   = tbl[i].dw;
            tick();
            expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].v, tbl[i].d, tbl[i].b);
        end

        // Owner 2, dwell 5: dropping req and changing its pattern mid-hold.
        RST = 1'b1; req = 4'h0; tick();
        RST = 1'b0; req = 4'h4; req_val = 16'h0600; dwell = 8'd5;
        tick();
        expect_out("hold1", 4'h4, 4'h6, 0, 1);
        req = 4'h0; req_val = 16'h0F00; dwell = 8'd1;
        for (int c = 2; c <= 5; c++) begin
            tick();
            expect_out($sformatf("hold%0d", c), 4'h4, 4'h6, c == 5, 1);
        end
        tick();
        expect_out("hold_end", 4'h0, 4'h0, 0, GAPEN);
        tick();

        // Reset mid-hold restarts arbitration at requester 0.
        req = 4'h2; req_val = 16'h0070; dwell = 8'd10;
        tick();
        expect_out("pre_rst", 4'h2, 4'h7, 0, 1);
        tick();
        RST = 1'b1; req = 4'hF; req_val = 16'h8421; dwell = 8'd1;
        tick();
        expect_out("mid_rst", 4'h0, 4'h0, 0, 0);
        RST = 1'b0;
        tick();
        expect_out("post_rst", 4'h1, 4'h1, 1, 1);
        req = 4'h0;
        tick();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            RST     = ($urandom_range(0, 63) == 0);
            req     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            req_val = 16'($urandom);
            dwell   = 8'($urandom_range(0, 4));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lane_scheduler.md
Name: lane_scheduler

Overview:
Round-robin arbiter that shares one WIDTH-bit VAL lane bus between NREQ requesters. The VAL bus fans out to an instance array of SUB cells that drive the LED outputs. Each grant latches the winner's pattern and holds it on VAL for a programmable dwell time, then moves to the next requester. It sits between the pattern sources and the SUB/LED instance array in TOP-level designs.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 4, VAL lane bus width (matches the SUB instance-array width)
CW, 8, dwell counter width

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous active-high reset
req  input  NREQ  per-requester request, level
req_val  input  NREQ*WIDTH  pattern per requester; slice i = [i*WIDTH +: WIDTH]
dwell  input  CW  hold cycles per grant; 0 treated as 1; sampled at grant
grant  output  NREQ  one-hot current owner; all-zero when no owner
VAL  output  WIDTH  latched pattern of the owner; 0 when no owner
done  output  1  one-cycle pulse in the last hold cycle of a grant
busy  output  1  high while in HOLD (or GAP)

Behaviour:
- Single clock domain, CLK. RST is synchronous and active-high.
- Reset (any state, including mid-hold): state=IDLE, grant=0, VAL=0, done=0, busy=0, counter=0, last owner pointer=NREQ-1 (so requester 0 wins first). All outputs are registered.
- States: IDLE, HOLD, GAP (GAP exists only with the feature).
- IDLE:
  - If req != 0 at edge t, pick the first set bit searching from (last+1) mod NREQ upward with wrap.
  - From edge t+1: grant=onehot(winner), VAL=req_val slice, busy=1.
  - Counter loads max(dwell,1)-1. Last pointer updates to winner. Go to HOLD.
- HOLD:
  - Counter decrements each cycle. grant and VAL stay stable.
  - req_val, dwell and req changes during HOLD are ignored; a requester dropping req does not shorten the hold.
  - done=1 in the cycle where the counter is 0.
- Exit from HOLD when the counter is 0 (feature off):
  - If any req is set, re-arbitrate in that same cycle. The next owner starts with no idle cycle (back-to-back).
  - A lone continuous requester is re-granted back-to-back. done pulses once per grant.
  - Otherwise go to IDLE: grant=0, VAL=0, busy=0.
- Latency: req to grant is 1 cycle. Grant length is exactly max(dwell,1) cycles.
- Fairness: a continuously requesting agent waits at most (NREQ-1) grants.
- Width: NREQ is not a power of two in general; the pointer wrap uses explicit compare, not overflow.

Optional Feature:
LANE_SCHED_GAP_EN
- Defined: after each HOLD, one GAP cycle with grant=0, VAL=0, busy=1, done=0. Arbitration happens in GAP, and the next grant starts the following cycle. Back-to-back grants are separated by exactly 1 blank cycle.
- Undefined: no GAP state, and handover is back-to-back as above.

Decomposition:
- Package lane_sched_pkg:
  - state enum (IDLE/HOLD/GAP)
  - function rr_pick(req, last) returning the winner index plus a valid flag
  - function onehot(idx)
- Natural sub-module: lane_rr_arbiter. It is purely combinational (req, last pointer) -> (winner, valid). The FSM, counter and output registers stay in lane_scheduler.

Test Plan:
- Reset then req=4'b0001, req_val[3:0]=4'hA, dwell=3 -> grant=0001 and VAL=A for exactly 3 cycles starting 1 cycle after req; done in the 3rd cycle; then grant=0, VAL=0.
- req=4'b1111 held, dwell=1, distinct patterns 1,2,4,8 -> grant order 0,1,2,3,0,... with no idle cycle; done high every cycle.
- Owner 2 granted with dwell=5; at hold cycle 2, drop req[2] and change req_val slice 2 -> VAL unchanged and the hold lasts 5 cycles.
- dwell=0 with a single requester -> 1-cycle grant with done asserted.
- RST asserted mid-HOLD -> next cycle grant=0, VAL=0, busy=0; the next arbitration starts from requester 0.
- With LANE_SCHED_GAP_EN defined, req=4'b0011, dwell=2 -> pattern grant0 x2, blank, grant1 x2, blank; VAL=0 in the blank cycles.
